// File: rtl/mag_comparator_seq_if.sv
// ----------------------------------------------------------------------------
// mag_comparator_seq_if
// Start/done handshake and result bundle for the digit-serial comparator.
//
// Parameters:
//   WIDTH  operand width in bits
//   DIGIT  bits compared per cycle (WIDTH must be a multiple of DIGIT)
//
// Signals:
//   start        master -> slave  request a compare (sampled while busy=0)
//   a, b         master -> slave  operands, captured on the start-accept edge
//   signed_mode  master -> slave  two's-complement compare
//                                 (only when MAG_CMP_SIGNED_EN is defined)
//   busy         slave -> master  compare in progress
//   done         slave -> master  one-cycle pulse, results valid from here
//   a_gt_b, a_lt_b, a_eq_b        result flags
//   digits       slave -> master  slices examined for the last result
// ----------------------------------------------------------------------------
interface mag_comparator_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) ();
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned DigW = $clog2(NDIG + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef MAG_CMP_SIGNED_EN
    logic             signed_mode;
`endif
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [DigW-1:0]  digits;

`ifdef MAG_CMP_SIGNED_EN
    modport master (
        output start, a, b, signed_mode,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, digits
    );
    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, digits
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, digits
    );
    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, digits
    );
`endif
endinterface

// File: rtl/mag_comparator_seq.sv
// ----------------------------------------------------------------------------
// mag_comparator_seq
// Digit-serial magnitude comparator. Compares two WIDTH-bit operands one
// DIGIT-bit slice per clock, MSB slice first, and stops at the first slice
// that differs. Equal operands take NDIG cycles; a difference found at slice
// i takes i+1 cycles.
//
// Optional feature macro: MAG_CMP_SIGNED_EN
//   Defined   : bus.signed_mode exists; when set, the MSB of slice 0 is
//               inverted on both operands so the unsigned slice compare
//               orders two's-complement values correctly.
//   Undefined : all compares are unsigned (signed_mode behaves as tied 0).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any compare in progress
//   bus    mag_comparator_seq_if.slave (start/a/b[/signed_mode] in,
//          busy/done/a_gt_b/a_lt_b/a_eq_b/digits out)
// ----------------------------------------------------------------------------
module mag_comparator_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mag_comparator_seq_if.slave       bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned DigW = $clog2(NDIG + 1);

    typedef enum logic {StIdle, StCmp} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             signed_q;
    logic [DigW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic [DigW-1:0]  digits_q;

    logic             signed_in;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic             last_slice;

`ifdef MAG_CMP_SIGNED_EN
    assign signed_in = bus.signed_mode;
`else
    assign signed_in = 1'b0;
`endif

    // Top slice of each shift register; in signed mode the sign bit of the
    // first slice is flipped so negative values sort below positive ones.
    always_comb begin
        slice_a = sa_q[WIDTH-1 -: DIGIT];
        slice_b = sb_q[WIDTH-1 -: DIGIT];
        if (signed_q && (idx_q == '0)) begin
            slice_a[DIGIT-1] = ~slice_a[DIGIT-1];
            slice_b[DIGIT-1] = ~slice_b[DIGIT-1];
        end
    end

    assign last_slice = (idx_q == DigW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            digits_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sa_q     <= bus.a;
                        sb_q     <= bus.b;
                        signed_q <= signed_in;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StCmp;
                    end
                end
                StCmp: begin
                    if (slice_a != slice_b) begin
                        gt_q     <= (slice_a > slice_b);
                        lt_q     <= (slice_a < slice_b);
                        eq_q     <= 1'b0;
                        digits_q <= idx_q + DigW'(1);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else if (last_slice) begin
                        gt_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        eq_q     <= 1'b1;
                        digits_q <= DigW'(NDIG);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        sa_q  <= sa_q << DIGIT;
                        sb_q  <= sb_q << DIGIT;
                        idx_q <= idx_q + DigW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_gt_b = gt_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_eq_b = eq_q;
    assign bus.digits = digits_q;
endmodule

// File: tb/tb_mag_comparator_seq.sv
// ----------------------------------------------------------------------------
// tb_mag_comparator_seq
// Directed bench for mag_comparator_seq (WIDTH=16, DIGIT=4). Expected results
// come from a whole-word reference model and are queued when a compare is
// issued, then popped when done is seen. Build with MAG_CMP_SIGNED_EN to also
// cover the signed-mode cases.
// ----------------------------------------------------------------------------
module tb_mag_comparator_seq;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;

    typedef struct packed {
        logic       gt;
        logic       lt;
        logic       eq;
        logic [2:0] digits;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mism;
    exp_t sb_q[$];

    mag_comparator_seq_if #(.WIDTH(W), .DIGIT(D)) bus ();

    mag_comparator_seq #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags from a whole-word compare; digits from the position of the most
    // significant differing bit.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sm);
        exp_t        e;
        logic [15:0] x;
        int          p;
        e.gt = sm ? ($signed(a) > $signed(b)) : (a > b);
        e.lt = sm ? ($signed(a) < $signed(b)) : (a < b);
        e.eq = (a == b);
        x = a ^ b;
        p = -1;
        for (int k = 0; k < 16; k++) if (x[k]) p = k;
        e.digits = (p < 0) ? 3'd4 : 3'((15 - p) / 4 + 1);
        return e;
    endfunction

    // Call at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm);
        bus.a = a;
        bus.b = b;
`ifdef MAG_CMP_SIGNED_EN
        bus.signed_mode = sm;
`endif
        bus.start = 1'b1;
        sb_q.push_back(model(a, b, sm));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("done_low_after_accept", 32'(bus.done), 32'd0);
    endtask

    // cyc0 = cycles already elapsed since the accept edge.
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        bit   found;
        exp_t e;
        cyc   = cyc0;
        found = 1'b0;
        while (cyc < 20 && !found) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        if (found) begin
            check({tag, "_gt"}, 32'(bus.a_gt_b), 32'(e.gt));
            check({tag, "_lt"}, 32'(bus.a_lt_b), 32'(e.lt));
            check({tag, "_eq"}, 32'(bus.a_eq_b), 32'(e.eq));
            check({tag, "_digits"}, 32'(bus.digits), 32'(e.digits));
            check({tag, "_latency"}, 32'(cyc), 32'(e.digits));
            check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          seen;
        n_cmp     = 0;
        n_mism    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef MAG_CMP_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 6: reset values, then idle with start=0 for 10 cycles.
        check("reset_outputs",
              32'({bus.busy, bus.done, bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.digits}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  32'({bus.busy, bus.done, bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.digits}),
                  32'd0);
        end

        // 1: decided at the first slice.
        issue(16'h9000, 16'h8000, 1'b0);
        wait_done("t1", 0);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(bus.done), 32'd0);
        check("t1_flags_hold", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'b100);

        // 2: equal operands take NDIG cycles.
        issue(16'h1234, 16'h1234, 1'b0);
        wait_done("t2", 0);

        // 3: back-to-back, second start asserted in the done cycle.
        @(negedge clk);
        issue(16'h0005, 16'h000B, 1'b0);
        wait_done("t3a", 0);
        issue(16'h00F0, 16'h0010, 1'b0);
        wait_done("t3b", 0);

        // 4a: start and operand changes while busy are ignored.
        @(negedge clk);
        issue(16'h1234, 16'h1235, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        check("t4_flags_stable_busy", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'b100);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_still_busy", 32'(bus.busy), 32'd1);
        wait_done("t4", 2);

        // 4b: reset mid-compare aborts with no done pulse.
        @(negedge clk);
        bus.a     = 16'h1234;
        bus.b     = 16'h1235;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_abort_outputs",
              32'({bus.busy, bus.done, bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.digits}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("t4_no_done_after_abort", 32'(seen), 32'd0);

`ifdef MAG_CMP_SIGNED_EN
        // 5: signed vs unsigned ordering of FFFF and 0001.
        issue(16'hFFFF, 16'h0001, 1'b1);
        wait_done("t5_signed", 0);
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("t5_unsigned", 0);
        @(negedge clk);
        issue(16'h7000, 16'h8000, 1'b1);
        wait_done("t5_signed_pos_neg", 0);
`endif

        // Mixed patterns: random, equal, and single-bit differences.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ra = 16'($urandom);
            unique case (i % 3)
                0: rb = 16'($urandom);
                1: rb = ra;
                default: rb = ra ^ (16'h0001 << $urandom_range(15, 0));
            endcase
            issue(ra, rb, 1'b0);
            wait_done("rand", 0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end
endmodule
